// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, byte width and bit-timing helper.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 2-flop synchroniser and mid-bit sampling byte receiver with glitch and framing checks.
// Define UART_RX_PARITY_EN to require an even-parity bit between bit 7 and the stop bit.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              uart_in,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              byte_valid,
    output logic              err,
    output logic              busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(half_bit(CLKS_PER_BIT) - 1);

    rx_state_e         state_q, state_d;
    logic [1:0]        sync_q, sync_d;
    logic              rx, rx_prev_q, rx_prev_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              par_bad_q;
`ifdef UART_RX_PARITY_EN
    logic              par_bad_d;
`else
    assign par_bad_q = 1'b0;
`endif

    assign rx         = sync_q[1];
    assign sync_d     = {sync_q[0], uart_in};
    assign rx_prev_d  = rx;
    assign rx_byte    = shift_q;
    assign byte_valid = valid_q;
    assign err        = err_q;
    assign busy       = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = (rx_prev_q && !rx) ? START : IDLE;
            end
            START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rx;
                    bit_d          = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    state_d        = (bit_q == 3'd7) ? PARITY : DATA;
`else
                    state_d        = (bit_q == 3'd7) ? STOP : DATA;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == FULL) begin
                    cnt_d     = '0;
                    par_bad_d = ^{shift_q, rx};
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                // Leaving at mid-stop leaves half a bit to catch the next start edge.
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    valid_d = rx && !par_bad_q;
                    err_d   = !rx || par_bad_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            bit_d   = '0;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            rx_prev_q <= rx_prev_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

endmodule

// File: rtl/uart_word_loader.sv
// uart_word_loader: packs received UART bytes little-endian into words and writes them to consecutive addresses.
// Parity checking in the receiver is enabled by defining UART_RX_PARITY_EN.
module uart_word_loader
    import uart_pkg::*;
#(
    parameter int                CLKS_PER_BIT   = 10417,
    parameter int                BYTES_PER_WORD = 4,
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        uart_in,
    output logic [ADDR_W-1:0]           addr,
    output logic [8*BYTES_PER_WORD-1:0] data,
    output logic                        wr,
    output logic                        frame_err,
    output logic                        busy
);

    localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
    localparam int IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES_PER_WORD - 1);

    logic [BYTE_W-1:0] rx_byte;
    logic              rx_valid, rx_err;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              wr_q, wr_d;
    logic              ferr_q, ferr_d;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .uart_in   (uart_in),
        .rx_byte   (rx_byte),
        .byte_valid(rx_valid),
        .err       (rx_err),
        .busy      (busy)
    );

    // Gating keeps a strobe already registered from escaping in the cycle enable drops.
    assign addr      = addr_q;
    assign data      = data_q;
    assign wr        = wr_q && enable;
    assign frame_err = ferr_q && enable;

    always_comb begin
        addr_d = wr_q ? addr_q + ADDR_W'(1) : addr_q;
        data_d = data_q;
        idx_d  = idx_q;
        wr_d   = 1'b0;
        ferr_d = rx_err;
        if (rx_valid) begin
            data_d[int'(idx_q) * BYTE_W +: BYTE_W] = rx_byte;
            wr_d  = idx_q == LAST;
            idx_d = (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);
        end
        if (!enable) begin
            addr_d = BASE_ADDR;
            data_d = '0;
            idx_d  = '0;
            wr_d   = 1'b0;
            ferr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= BASE_ADDR;
            data_q <= '0;
            idx_q  <= '0;
            wr_q   <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
            idx_q  <= idx_d;
            wr_q   <= wr_d;
            ferr_q <= ferr_d;
        end
    end

endmodule
